// File: rtl/i2s_dac_tx_if.sv
// Sample stream from the equalizer DSP into the I2S DAC transmitter.
// The DSP drives a single-cycle valid strobe alongside a signed sample.
interface i2s_dac_tx_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              valid;

  modport master (
    output data,
    output valid
  );

  modport slave (
    input data,
    input valid
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S slave transmitter: serializes mono DSP samples into both codec slots.
// The codec owns BCLK and DACLRCK; this block only drives DACDAT, one bit
// after each LRCK edge, MSB first, updated on synchronized BCLK falling edges.
// Optional build macro I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun
// counter (o_underrun_cnt) with a synchronous clear pulse (i_cnt_clr).
module i2s_dac_tx #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  i2s_dac_tx_if.slave dsp,
  input  logic        i_bclk,
  input  logic        i_daclrck,
  output logic        o_dacdat,
  output logic        o_underrun,
  output logic        o_overrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] o_underrun_cnt,
  input  logic        i_cnt_clr
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StShift,
    StPad
  } state_e;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic                   bclk_hist_q;
  logic                   lrck_hist_q;

  logic [DATA_W-1:0] hold_q;
  logic              hold_valid_q;
  logic [DATA_W-1:0] cur_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  count_q;
  state_e            state_q;

  logic bclk_s;
  logic lrck_s;
  logic bfall;
  logic lfall;
  logic lrise;
  logic consume;

  // Bring the codec clocks into i_clk and keep one history bit for edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_hist_q <= 1'b0;
      lrck_hist_q <= 1'b0;
    end else begin
      bclk_sync_q[0] <= i_bclk;
      lrck_sync_q[0] <= i_daclrck;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sync_q[i] <= bclk_sync_q[i-1];
        lrck_sync_q[i] <= lrck_sync_q[i-1];
      end
      bclk_hist_q <= bclk_sync_q[SYNC_STAGES-1];
      lrck_hist_q <= lrck_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge events and buffer consumption, all in the i_clk domain.
  always_comb begin
    bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    lrck_s  = lrck_sync_q[SYNC_STAGES-1];
    bfall   = bclk_hist_q & ~bclk_s;
    lfall   = lrck_hist_q & ~lrck_s;
    lrise   = ~lrck_hist_q & lrck_s;
    // Every left-slot start drains the holding buffer, even from idle.
    consume = lfall & hold_valid_q;
  end

  // Holding buffer, slot loads, serializer FSM and status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      cur_q        <= '0;
      shift_q      <= '0;
      count_q      <= '0;
      state_q      <= StIdle;
      o_dacdat     <= 1'b0;
      o_underrun   <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;

      // A new sample always lands; a load in the same cycle took the old one.
      if (dsp.valid) begin
        hold_q       <= dsp.data;
        hold_valid_q <= 1'b1;
        if (hold_valid_q && !consume) begin
          o_overrun <= 1'b1;
        end
      end else if (consume) begin
        hold_valid_q <= 1'b0;
      end

      // LRCK edges win over BCLK; a coincident bfall is not the delay bit.
      if (lfall || (lrise && state_q != StIdle)) begin
        count_q  <= '0;
        state_q  <= StDelay;
        o_dacdat <= 1'b0;
        if (lfall) begin
          if (hold_valid_q) begin
            cur_q   <= hold_q;
            shift_q <= hold_q;
          end else begin
            shift_q    <= cur_q;
            o_underrun <= 1'b1;
          end
        end else begin
          shift_q <= cur_q;
        end
      end else begin
        case (state_q)
          StIdle: begin
            o_dacdat <= 1'b0;
          end
          StDelay: begin
            if (bfall) begin
              o_dacdat <= shift_q[DATA_W-1];
              shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
              count_q  <= CNT_W'(1);
              state_q  <= StShift;
            end
          end
          StShift: begin
            if (bfall) begin
              if (count_q < CNT_W'(DATA_W)) begin
                o_dacdat <= shift_q[DATA_W-1];
                shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
                count_q  <= count_q + CNT_W'(1);
              end else begin
                o_dacdat <= 1'b0;
                state_q  <= StPad;
              end
            end
          end
          StPad: begin
            o_dacdat <= 1'b0;
          end
          default: begin
            o_dacdat <= 1'b0;
            state_q  <= StIdle;
          end
        endcase
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating underrun tally; a clear pulse beats a same-cycle increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_underrun_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_underrun_cnt <= '0;
    end else if (o_underrun && (o_underrun_cnt != 16'hFFFF)) begin
      o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: plays the codec (BCLK/LRCK master) and the DSP.
// A slot-level model pushes the word expected in each slot into a queue; a
// monitor on BCLK rising edges collects DACDAT per slot and compares.
module tb_i2s_dac_tx;

  localparam int unsigned DW   = 16;
  localparam int          SYNC = 2;

  logic clk = 1'b0;
  logic rst;
  logic bclk;
  logic lrck;
  logic dacdat;
  logic underrun;
  logic overrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ur_cnt;
  logic        cnt_clr;
`endif

  always #5 clk = ~clk;

  i2s_dac_tx_if #(.DATA_W(DW)) dsp_if ();

  i2s_dac_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .dsp            (dsp_if),
    .i_bclk         (bclk),
    .i_daclrck      (lrck),
    .o_dacdat       (dacdat),
    .o_underrun     (underrun),
    .o_overrun      (overrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt (ur_cnt),
    .i_cnt_clr      (cnt_clr)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Slot-level reference state.
  logic [15:0] pend;
  logic [15:0] cur;
  bit          pend_v;
  bit          aligned;
  int          exp_ur;
  int          exp_ov;
  int          exp_cnt;
  int          seen_ur;
  int          seen_ov;
  bit          abort;
  logic [15:0] sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Left slot start: send the pending sample or repeat the last one.
  function automatic void model_frame();
    if (pend_v) begin
      cur    = pend;
      pend_v = 1'b0;
    end else begin
      exp_ur++;
      exp_cnt++;
    end
    aligned = 1'b1;
    sb_q.push_back(cur);
  endfunction

  // Right slot start: same word as the left, or silence while unaligned.
  function automatic void model_right();
    sb_q.push_back(aligned ? cur : 16'h0000);
  endfunction

  function automatic void model_valid(input logic [15:0] d);
    if (pend_v) exp_ov++;
    pend   = d;
    pend_v = 1'b1;
  endfunction

  function automatic void model_reset();
    pend_v  = 1'b0;
    pend    = '0;
    cur     = '0;
    aligned = 1'b0;
    exp_cnt = 0;
    abort   = 1'b1;
  endfunction

  // One codec slot of nb BCLKs (16 i_clk each); optional valid and reset ticks.
  task automatic run_slot(input logic lr, input int nb, input int vtick,
                          input logic [15:0] vd, input int rtick);
    bit changed;
    changed = (lr !== lrck);
    for (int t = 0; t < nb * 16; t++) begin
      @(negedge clk);
      bclk          = ((t % 16) >= 8);
      lrck          = lr;
      dsp_if.valid  = (t == vtick);
      dsp_if.data   = (t == vtick) ? vd : 16'($urandom);
      rst           = (t == rtick);
      // The design sees an LRCK fall SYNC ticks after the pad moves.
      if (changed && lr && t == 0) model_right();
      if (changed && !lr && t == SYNC) model_frame();
      if (t == vtick) model_valid(vd);
      if (t == rtick) begin
        model_reset();
        #1;
        check("rst_async_dacdat", 64'(dacdat), 64'(0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("rst_async_cnt", 64'(ur_cnt), 64'(0));
`endif
      end
    end
  endtask

  task automatic run_frame(input int nb, input int vl, input logic [15:0] dl,
                           input int vr, input logic [15:0] dr);
    run_slot(1'b0, nb, vl, dl, -1);
    run_slot(1'b1, nb, vr, dr, -1);
  endtask

  task automatic check_flags(input string name);
    check({name, "_underruns"}, 64'(seen_ur), 64'(exp_ur));
    check({name, "_overruns"}, 64'(seen_ov), 64'(exp_ov));
  endtask

  // Count status pulses as the design presents them.
  always @(negedge clk) begin
    if (underrun === 1'b1) seen_ur++;
    if (overrun === 1'b1) seen_ov++;
  end

  // Per-slot capture at the codec sampling edge, compared at the next slot start.
  logic        mon_lr   = 1'b1;
  bit          mon_have = 1'b0;
  logic [15:0] mon_word;
  logic [63:0] mon_bits = '0;
  logic [63:0] mon_exp;
  int          mon_r    = 0;
  int          slot_no  = 0;

  always @(posedge bclk) begin
    if (lrck !== mon_lr) begin
      if (mon_have && !abort) begin
        mon_exp = '0;
        for (int r = 1; r < mon_r && r <= DW; r++) mon_exp[r] = mon_word[DW-r];
        check($sformatf("slot%0d_bits", slot_no), mon_bits, mon_exp);
      end
      abort    = 1'b0;
      mon_lr   = lrck;
      mon_r    = 0;
      mon_bits = '0;
      slot_no++;
      if (sb_q.size() == 0) begin
        mon_have = 1'b0;
        check($sformatf("slot%0d_expected_entry", slot_no), 64'(0), 64'(1));
      end else begin
        mon_word = sb_q.pop_front();
        mon_have = 1'b1;
      end
    end
    if (mon_r < 64) mon_bits[mon_r] = dacdat;
    mon_r++;
  end

  initial begin
    int vl;
    int vr;
    rst          = 1'b1;
    bclk         = 1'b0;
    lrck         = 1'b1;
    dsp_if.valid = 1'b0;
    dsp_if.data  = '0;
    pend         = '0;
    cur          = '0;
    pend_v       = 1'b0;
    aligned      = 1'b0;
    abort        = 1'b0;
    exp_ur       = 0;
    exp_ov       = 0;
    exp_cnt      = 0;
    seen_ur      = 0;
    seen_ov      = 0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_dacdat", 64'(dacdat), 64'(0));
    check("reset_underrun", 64'(underrun), 64'(0));
    check("reset_overrun", 64'(overrun), 64'(0));
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("reset_cnt", 64'(ur_cnt), 64'(0));
`endif
    rst = 1'b0;

    // Preload A5C3 before the first left slot; basic frame, then queue 7FFF.
    run_slot(1'b1, 4, 20, 16'hA5C3, -1);
    run_frame(32, -1, 16'h0, 100, 16'h7FFF);
    check_flags("basic");

    // 7FFF goes out, then a starved frame repeats it.
    run_frame(32, -1, 16'h0, -1, 16'h0);
    run_frame(32, 50, 16'h1234, 60, 16'h8001);
    check_flags("underrun_overrun");

    // 8001 goes out with F00F queued; 00FF coincides with the left-slot load.
    run_frame(32, -1, 16'h0, 300, 16'hF00F);
    run_frame(32, SYNC, 16'h00FF, -1, 16'h0);
    run_frame(32, -1, 16'h0, -1, 16'h0);
    check_flags("simultaneous");

    // Random sample timing and data, including strobes on the load cycle.
    for (int f = 0; f < 6; f++) begin
      vl = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 511));
      if ($urandom_range(0, 4) == 0) vl = SYNC;
      vr = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 511));
      run_frame(32, vl, 16'($urandom), vr, 16'($urandom));
    end
    check_flags("random");

    // Short slots of 8 BCLKs carrying all-ones samples.
    run_frame(32, -1, 16'h0, 200, 16'hFFFF);
    for (int f = 0; f < 3; f++) run_frame(8, 60, 16'hFFFF, -1, 16'h0);
    run_frame(32, -1, 16'h0, 100, 16'h1357);
    check_flags("short_slot");

    // Reset during bit 5 of a left slot, then realign on the next frame.
    run_slot(1'b0, 32, -1, 16'h0, 5 * 16 + 12);
    run_slot(1'b1, 32, 50, 16'h2468, -1);
    run_frame(32, -1, 16'h0, -1, 16'h0);
    for (int f = 0; f < 3; f++) run_frame(32, -1, 16'h0, -1, 16'h0);
    check_flags("reset_resume");
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("cnt_after_starved", 64'(ur_cnt), 64'(exp_cnt));
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    check("cnt_cleared", 64'(ur_cnt), 64'(exp_cnt));
`endif

    // A short trailing left slot closes out the last full right slot.
    run_slot(1'b0, 2, -1, 16'h0, -1);
    @(negedge clk);
    dsp_if.valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
I2S slave transmitter that takes processed 16-bit samples from the equalizer DSP output (i_data/i_valid driven by its o_data/o_done strobe) and serializes them to the audio codec DAC.
- The codec is the bus master and drives BCLK and DACLRCK; this block drives DACDAT only.
- Mono DSP samples are duplicated into the left and right slots.
- Sits between the DSP chain and the codec DAC pins, mirroring the ADC-side receiver that produces i_doneR.

Parameters:
- DATA_W, 16: sample width in bits; also the number of bits shifted per slot.
- SYNC_STAGES, 2: flip-flop stages used to synchronize i_bclk and i_daclrck into i_clk.

Ports:
- i_clk  in  1  system clock; must be at least 8x the BCLK frequency.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  DATA_W  signed sample from the DSP; sampled only when i_valid=1.
- i_valid  in  1  single-cycle sample strobe from the DSP.
- i_bclk  in  1  codec bit clock, asynchronous to i_clk.
- i_daclrck  in  1  codec DAC LR clock, asynchronous; 0 = left slot, 1 = right slot.
- o_dacdat  out  1  serial data to the codec.
- o_underrun  out  1  1-cycle pulse: a left slot started with no new sample pending.
- o_overrun  out  1  1-cycle pulse: i_valid arrived while a sample was already pending.

Behaviour:
- Reset values: o_dacdat=0, o_underrun=0, o_overrun=0. Also: hold/cur/shift registers=0, hold_valid=0, bit count=0, state=S_IDLE.
- Synchronization and edge detection:
  - i_bclk and i_daclrck each pass through SYNC_STAGES FFs, then one history FF for edge detection.
  - Edge detection therefore lags the pads by SYNC_STAGES+1 i_clk cycles.
- Events:
  - bfall = synchronized BCLK 1->0.
  - lfall = synchronized LRCK 1->0 (left slot start).
  - lrise = synchronized LRCK 0->1 (right slot start).
- Holding buffer (one entry):
  - On i_valid: hold_r<=i_data and hold_valid<=1.
  - If hold_valid was already 1 (and is not being consumed this cycle), the old sample is overwritten and o_overrun pulses.
- Left-slot load on lfall:
  - If hold_valid: cur_r<=hold_r, shift_r<=hold_r, hold_valid<=0.
  - Otherwise: shift_r<=cur_r (repeat the last sample) and o_underrun pulses.
- Right-slot load on lrise: shift_r<=cur_r.
- Simultaneous lfall and i_valid:
  - The load consumes the old hold_r if one is pending.
  - The new i_data lands in hold_r with hold_valid=1, and o_overrun does not pulse.
  - If nothing was pending, the load is an underrun and the new sample waits for the next frame.
- State machine (all moves except reset are evaluated on i_clk):
  - S_IDLE: o_dacdat=0. Ignores bfall and lrise. On lfall: load, count<=0, go to S_DELAY. This aligns to a full frame after reset.
  - S_DELAY: the I2S 1-bit delay slot; o_dacdat holds 0. On bfall: o_dacdat<=shift_r[DATA_W-1], shift left, count<=1, go to S_SHIFT.
  - S_SHIFT: on bfall, if count<DATA_W: output the next MSB, shift, count+1. If count==DATA_W: o_dacdat<=0 and go to S_PAD.
  - S_PAD: o_dacdat=0 until the next LRCK edge.
- In S_DELAY, S_SHIFT and S_PAD, lfall or lrise has priority:
  - Perform the corresponding load, count<=0, go to S_DELAY.
  - A bfall detected in the same cycle is consumed by the LRCK edge and does not count as the delay bit.
- Short slot (fewer than DATA_W+1 BCLKs per slot): the remaining bits are dropped and the next slot restarts at the MSB. No error flag.
- o_dacdat changes only on bfall or LRCK edges, at a fixed SYNC_STAGES+1 cycle lag. The codec samples on the BCLK rising edge, half a BCLK later.
- Reset mid-operation clears everything immediately; the block realigns at the next lfall.

Optional Feature:
- Macro I2S_TX_UNDERRUN_CNT_EN.
- When defined:
  - Adds output o_underrun_cnt [15:0], which increments on each o_underrun pulse and saturates at 16'hFFFF.
  - Reset value is 0.
  - Adds input i_cnt_clr; a 1-cycle pulse clears the count, and clear wins over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Basic frame (BCLK=16 i_clk cycles, 32 BCLKs per slot): i_valid with 16'hA5C3 before lfall -> both left and right slots carry 1010010111000011 MSB-first, starting at the 2nd BCLK after each LRCK edge, then 0 padding; no flags.
- Underrun: no i_valid for a frame after 16'h7FFF was sent -> the next frame repeats 16'h7FFF in both slots; o_underrun pulses exactly once at lfall.
- Overrun: i_valid 16'h1234 then 16'h8001 within one frame -> o_overrun pulses once; the next frame sends 16'h8001.
- Simultaneous: i_valid 16'h00FF in the same i_clk cycle as lfall, with 16'hF00F pending -> this frame sends F00F, the next frame sends 00FF, and o_overrun=0.
- Short slot: 8 BCLKs per slot with sample 16'hFFFF -> each slot is 1 delay bit plus 7 ones, then restarts at the MSB; no hang.
- Reset mid-shift: assert i_rst at bit 5 of the left slot -> o_dacdat=0 immediately; no output until the next lfall, then normal frames resume. Underrun counter (if built): reads 0 after reset, counts 3 after three starved frames, and clears on i_cnt_clr.
